// File: rtl/tmds_word_scheduler.sv
// Feeds one 10-bit TMDS word every 5 shift clocks to a 2-bit/cycle DDR serializer, inserting idle/training symbols.
// Latency: a word accepted at phase 4 appears on o_word the next cycle (phase 0) and holds for 5 cycles.
// Backpressure: o_ready only at phase 4 when the next slot is STREAM; a starved slot sends IDLE_WORD and is counted.
module tmds_word_scheduler #(
    parameter logic [9:0] IDLE_WORD   = 10'b1101010100,
    parameter logic [9:0] TRAIN_WORD  = 10'b1111100000,
    parameter int         TRAIN_WORDS = 64,
    parameter int         CNT_W       = 16
) (
    input  logic             i_clk_shift,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_train,
    input  logic             i_clr_stats,
    input  logic             i_valid,
    input  logic [9:0]       i_data,
    output logic             o_ready,
    output logic [9:0]       o_word,
    output logic             o_word_strobe,
    output logic [2:0]       o_phase,
    output logic             o_training,
    output logic [CNT_W-1:0] o_underflow_cnt
);

    localparam int TC_W = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_TRAIN} state_t;

    state_t          state;
    state_t          next_state;
    logic [2:0]      phase;
    logic            pending;
    logic [TC_W-1:0] train_cnt;
    logic            boundary;
    logic            enter_train;

    assign boundary    = (phase == 3'd4);
    assign enter_train = boundary && (next_state == ST_TRAIN) && (state != ST_TRAIN);

    // State only moves at the word boundary; mid-word the current decision is frozen.
    always_comb begin
        next_state = state;
        if (boundary) begin
            case (state)
                ST_IDLE: begin
                    if (i_enable && pending)   next_state = ST_TRAIN;
                    else if (i_enable)         next_state = ST_STREAM;
                    else                       next_state = ST_IDLE;
                end
                ST_STREAM: begin
                    if (!i_enable)             next_state = ST_IDLE;
                    else if (pending)          next_state = ST_TRAIN;
                    else                       next_state = ST_STREAM;
                end
                ST_TRAIN: begin
                    if (!i_enable)             next_state = ST_IDLE;
                    else if (train_cnt == '0)  next_state = ST_STREAM;
                    else                       next_state = ST_TRAIN;
                end
                default:                       next_state = ST_IDLE;
            endcase
        end
    end

    assign o_ready    = boundary && (next_state == ST_STREAM);
    assign o_phase    = phase;
    assign o_training = (state == ST_TRAIN);

    always_ff @(posedge i_clk_shift or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase           <= 3'd0;
            state           <= ST_IDLE;
            o_word          <= IDLE_WORD;
            o_word_strobe   <= 1'b0;
            pending         <= 1'b0;
            train_cnt       <= '0;
            o_underflow_cnt <= '0;
        end else begin
            phase         <= boundary ? 3'd0 : phase + 3'd1;
            o_word_strobe <= boundary;

            if (enter_train)
                pending <= 1'b0;
            else if (i_train && (state != ST_TRAIN))
                pending <= 1'b1;

            if (boundary) begin
                state <= next_state;
                case (next_state)
                    ST_STREAM: o_word <= i_valid ? i_data : IDLE_WORD;
                    ST_TRAIN:  o_word <= TRAIN_WORD;
                    default:   o_word <= IDLE_WORD;
                endcase
            end

            if (enter_train)
                train_cnt <= TC_W'(TRAIN_WORDS - 1);
            else if (boundary && (state == ST_TRAIN) && (train_cnt != '0))
                train_cnt <= train_cnt - 1'b1;

            // A clear in the same cycle as a starved slot leaves the count at zero.
            if (i_clr_stats)
                o_underflow_cnt <= '0;
            else if (boundary && (next_state == ST_STREAM) && !i_valid && (o_underflow_cnt != '1))
                o_underflow_cnt <= o_underflow_cnt + 1'b1;
        end
    end

endmodule
